me_search_controller: RTL and testbench



---
 rtl/me_search_controller_if.sv | 34 +++
 rtl/me_search_controller.sv | 136 +++++++++++++
 tb/tb_me_search_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/me_search_controller_if.sv
// Handshake/bus bundle between the motion-estimator sequencer and its datapath.
// ME_ABORT_EN adds the abort input.
interface me_search_controller_if #(
  parameter int unsigned NUM_PE = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic [7:0]        AddressR;
  logic [NUM_PE-1:0] newDist;
  logic [NUM_PE-1:0] PEready;
  logic              CompStart;
  logic [3:0]        vectorX;
  logic [3:0]        vectorY;
`ifdef ME_ABORT_EN
  logic              abort;
`endif

  modport master (
`ifdef ME_ABORT_EN
    input  abort,
`endif
    input  start,
    output busy, done, AddressR, newDist, PEready, CompStart, vectorX, vectorY
  );

  modport slave (
`ifdef ME_ABORT_EN
    output abort,
`endif
    output start,
    input  busy, done, AddressR, newDist, PEready, CompStart, vectorX, vectorY
  );
endinterface

// File: rtl/me_search_controller.sv
// Full-search sequencing FSM for the systolic motion-estimator PE array.
// Optional macro ME_ABORT_EN adds an abort input that returns RUN to IDLE.
module me_search_controller #(
  parameter int unsigned NUM_PE    = 16,
  parameter int unsigned NUM_Y     = 16,
  parameter int unsigned BLOCK_PIX = 256
) (
  input  logic                   clock,
  input  logic                   reset_n,
  me_search_controller_if.master bus
);
  localparam int unsigned   CW      = 13;
  localparam int unsigned   PB      = $clog2(BLOCK_PIX);
  localparam int unsigned   SPAN    = NUM_Y * BLOCK_PIX;
  localparam logic [CW-1:0] LAST    = CW'(SPAN + NUM_PE - 1);
  localparam logic [CW-1:0] SPAN_C  = CW'(SPAN);
  localparam logic [CW-1:0] FIRST_C = CW'(BLOCK_PIX);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              comp_q, comp_d;
  logic [7:0]        addr_q, addr_d;
  logic [NUM_PE-1:0] nd_q, nd_d;
  logic [NUM_PE-1:0] pe_q, pe_d;
  logic [3:0]        vx_q, vx_d;
  logic [3:0]        vy_q, vy_d;
  logic              abort;

`ifdef ME_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state/count and registered, so each
  // registered output lines up with the cnt value held in the same cycle.
  always_comb begin : decode
    logic [CW-1:0] p;
    p      = '0;
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    comp_d = (state_d != IDLE);
    addr_d = '0;
    nd_d   = '0;
    pe_d   = '0;
    vx_d   = vx_q;
    vy_d   = vy_q;
    if (state_d == RUN) begin
      if (cnt_d < SPAN_C) addr_d = cnt_d[7:0];
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (cnt_d >= CW'(i)) begin
          p = cnt_d - CW'(i);
          if (p[PB-1:0] == '0) begin
            if (p < SPAN_C) nd_d[i] = 1'b1;
            if ((p >= FIRST_C) && (p <= SPAN_C)) begin
              pe_d[i] = 1'b1;
              vx_d    = 4'(i);
              vy_d    = 4'((p >> PB) - 1'b1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      comp_q  <= 1'b0;
      addr_q  <= '0;
      nd_q    <= '0;
      pe_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      comp_q  <= comp_d;
      addr_q  <= addr_d;
      nd_q    <= nd_d;
      pe_q    <= pe_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.CompStart = comp_q;
  assign bus.AddressR  = addr_q;
  assign bus.newDist   = nd_q;
  assign bus.PEready   = pe_q;
  assign bus.vectorX   = vx_q;
  assign bus.vectorY   = vy_q;
endmodule

// File: tb/tb_me_search_controller.sv
// Self-checking bench for me_search_controller: candidate-schedule tables as reference,
// randomized start noise, idle gaps and reset points.
module tb_me_search_controller;
  localparam int NPE  = 16;
  localparam int LAST = 4111;
  localparam int SPAN = 4096;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  me_search_controller_if #(.NUM_PE(NPE)) bus ();

  me_search_controller #(
    .NUM_PE   (16),
    .NUM_Y    (16),
    .BLOCK_PIX(256)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int          vectors     = 0;
  int          miscompares = 0;
  int          pe_x  [0:LAST];
  int          pe_y  [0:LAST];
  logic [15:0] nd_exp[0:LAST];
  int          last_x = 0;
  int          last_y = 0;
  int          seen  [0:15][0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},      32'(bus.busy),      32'd0);
    check({tag, ".done"},      32'(bus.done),      32'd0);
    check({tag, ".CompStart"}, 32'(bus.CompStart), 32'd0);
    check({tag, ".AddressR"},  32'(bus.AddressR),  32'd0);
    check({tag, ".newDist"},   32'(bus.newDist),   32'd0);
    check({tag, ".PEready"},   32'(bus.PEready),   32'd0);
    check({tag, ".vectorX"},   32'(bus.vectorX),   32'(last_x));
    check({tag, ".vectorY"},   32'(bus.vectorY),   32'(last_y));
  endtask

  task automatic idle_gap(input int n);
    for (int j = 0; j < n; j++) begin
      check_idle("idle");
      @(posedge clock); #1;
    end
  endtask

  task automatic run_search(input int rst_at, input int abort_at);
    int pulses      = 0;
    int busy_cycles = 0;
    int distinct    = 0;
    logic [31:0] pe_mask;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) seen[x][y] = 0;
    bus.start = 1'b1;
    @(posedge clock); #1;
    for (int k = 0; k <= LAST; k++) begin
      bus.start = (k == 500) ? 1'b1 : 1'($urandom_range(0, 1));
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        last_x = 0;
        last_y = 0;
        check_idle("async_rst");
        bus.start = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        check_idle("post_rst");
        return;
      end
      if (pe_x[k] >= 0) begin
        last_x  = pe_x[k];
        last_y  = pe_y[k];
        pe_mask = 32'd1 << pe_x[k];
      end else begin
        pe_mask = 32'd0;
      end
      check("run.busy",      32'(bus.busy),      32'd1);
      check("run.done",      32'(bus.done),      32'd0);
      check("run.CompStart", 32'(bus.CompStart), 32'd1);
      check("run.AddressR",  32'(bus.AddressR),  (k < SPAN) ? 32'(k % 256) : 32'd0);
      check("run.newDist",   32'(bus.newDist),   32'(nd_exp[k]));
      check("run.PEready",   32'(bus.PEready),   pe_mask);
      check("run.vectorX",   32'(bus.vectorX),   32'(last_x));
      check("run.vectorY",   32'(bus.vectorY),   32'(last_y));
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.PEready != '0) begin
        pulses++;
        seen[bus.vectorX][bus.vectorY]++;
      end
`ifdef ME_ABORT_EN
      if (k == abort_at) begin
        bus.abort = 1'b1;
        @(posedge clock); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_idle("abort");
        @(posedge clock); #1;
        check_idle("abort_idle");
        return;
      end
`endif
      @(posedge clock); #1;
    end
    bus.start = 1'b1;
    check("done.done",      32'(bus.done),      32'd1);
    check("done.busy",      32'(bus.busy),      32'd0);
    check("done.CompStart", 32'(bus.CompStart), 32'd1);
    check("done.PEready",   32'(bus.PEready),   32'd0);
    check("done.newDist",   32'(bus.newDist),   32'd0);
    check("done.AddressR",  32'(bus.AddressR),  32'd0);
    check("done.vectorX",   32'(bus.vectorX),   32'(last_x));
    check("done.vectorY",   32'(bus.vectorY),   32'(last_y));
    @(posedge clock); #1;
    bus.start = 1'b0;
    check_idle("after_done");
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        if (seen[x][y] == 1) distinct++;
    check("sweep.pulses",   32'(pulses),      32'd256);
    check("sweep.distinct", 32'(distinct),    32'd256);
    check("sweep.busy",     32'(busy_cycles), 32'd4112);
  endtask

  initial begin
    bus.start = 1'b0;
`ifdef ME_ABORT_EN
    bus.abort = 1'b0;
`endif
    // Candidate (x,y) reports at 256*(y+1)+x; PE x starts pass n at 256*n+x.
    for (int k = 0; k <= LAST; k++) begin
      pe_x[k]   = -1;
      pe_y[k]   = -1;
      nd_exp[k] = '0;
    end
    for (int n = 0; n < 16; n++)
      for (int x = 0; x < 16; x++) nd_exp[256*n + x][x] = 1'b1;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        pe_x[256*(y+1) + x] = x;
        pe_y[256*(y+1) + x] = y;
      end

    #1 reset_n = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    check_idle("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    idle_gap($urandom_range(1, 5));

    run_search(-1, -1);
    run_search(-1, -1);
    idle_gap($urandom_range(1, 4));
    run_search(1000, -1);
    idle_gap($urandom_range(1, 4));
    run_search($urandom_range(1, LAST), -1);
    idle_gap(2);
    run_search(-1, -1);
`ifdef ME_ABORT_EN
    idle_gap(2);
    run_search(-1, 300);
    run_search(-1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
